// File: rtl/store_fsm.sv
// store_fsm: STORE instruction sequencer, MEM[src(p1)] <- src(p2), with Moore outputs registered from next state.
module store_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       donefetch,
  input  logic       start,
  input  logic [5:0] parameter1,
  input  logic [5:0] parameter2,
  output logic       R0OutEn,
  output logic       R1OutEn,
  output logic       R2OutEn,
  output logic       R3OutEn,
  output logic       P0OutEn,
  output logic       Regiout,
  output logic       Regjout,
  output logic       MARin,
  output logic       MDR_frombusin,
  output logic       EN,
  output logic       RW,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  p1_q, p1_d, p2_q, p2_d, sel;
  logic [6:0]  src;
  logic [11:0] out_q, out_d;
  logic        go;
  always_comb begin
    go = 1'b0;
    if (state_q == IDLE && start && donefetch) go = 1'b1;
    p1_d = go ? parameter1 : p1_q;
    p2_d = go ? parameter2 : p2_q;
    state_d = go ? ADDR :
              state_q == ADDR  ? DATA  :
              state_q == DATA  ? WRITE :
              state_q == WRITE ? DONE  : IDLE;
    // outputs are decoded one cycle early so they can be flopped alongside the state
    sel = state_d == ADDR ? p1_d : p2_d;
    src = ((state_d == ADDR || state_d == DATA) && sel < 6'd7) ? 7'b1000000 >> sel[2:0] : 7'b0;
    out_d = {src, state_d == ADDR, state_d == DATA, state_d == WRITE, state_d == WRITE, state_d == DONE};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      out_q   <= out_d;
    end
  end
  assign {R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn, Regiout, Regjout,
          MARin, MDR_frombusin, EN, RW, done} = out_q;
endmodule

// File: tb/tb_store_fsm.sv
// tb_store_fsm: directed tests for the STORE sequencer.
module tb_store_fsm;
  logic clk = 1'b0, rst = 1'b1, donefetch = 1'b0, start = 1'b0;
  logic [5:0] parameter1 = '0, parameter2 = '0;
  logic R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn, Regiout, Regjout;
  logic MARin, MDR_frombusin, EN, RW, done;
  logic [11:0] obs;
  int tests = 0, fails = 0;

  // bit order: R0 R1 R2 R3 P0 Ri Rj MAR MDR EN RW done
  localparam logic [11:0] Z   = 12'b000000000000;
  localparam logic [11:0] WR  = 12'b000000000110;
  localparam logic [11:0] DN  = 12'b000000000001;

  store_fsm dut (
    .clk(clk), .rst(rst), .donefetch(donefetch), .start(start),
    .parameter1(parameter1), .parameter2(parameter2),
    .R0OutEn(R0OutEn), .R1OutEn(R1OutEn), .R2OutEn(R2OutEn), .R3OutEn(R3OutEn),
    .P0OutEn(P0OutEn), .Regiout(Regiout), .Regjout(Regjout), .MARin(MARin),
    .MDR_frombusin(MDR_frombusin), .EN(EN), .RW(RW), .done(done)
  );

  assign obs = {R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn, Regiout, Regjout,
                MARin, MDR_frombusin, EN, RW, done};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL reset_t0 got=%b exp=%b", obs, Z); end
    repeat (3) step();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL reset_hold got=%b exp=%b", obs, Z); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL reset_idle got=%b exp=%b", obs, Z); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    parameter1 = 6'd4; parameter2 = 6'd2; start = 1'b1; donefetch = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (obs !== 12'b000010010000) begin fails++; $display("FAIL basic_addr got=%b exp=%b", obs, 12'b000010010000); end
    step();
    tests++;
    if (obs !== 12'b001000001000) begin fails++; $display("FAIL basic_data got=%b exp=%b", obs, 12'b001000001000); end
    step();
    tests++;
    if (obs !== WR) begin fails++; $display("FAIL basic_write got=%b exp=%b", obs, WR); end
    step();
    tests++;
    if (obs !== DN) begin fails++; $display("FAIL basic_done got=%b exp=%b", obs, DN); end
    step();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL basic_idle got=%b exp=%b", obs, Z); end
  endtask

  task automatic test_gating();
    @(negedge clk);
    parameter1 = 6'd0; parameter2 = 6'd1; start = 1'b1; donefetch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (obs !== Z) begin fails++; $display("FAIL gate_df0 got=%b exp=%b", obs, Z); end
    end
    @(negedge clk);
    donefetch = 1'bx;
    step();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL gate_dfx got=%b exp=%b", obs, Z); end
    @(negedge clk);
    donefetch = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (obs !== 12'b100000010000) begin fails++; $display("FAIL gate_go got=%b exp=%b", obs, 12'b100000010000); end
    step();
    tests++;
    if (obs !== 12'b010000001000) begin fails++; $display("FAIL gate_data got=%b exp=%b", obs, 12'b010000001000); end
    repeat (2) step();
    tests++;
    if (obs !== DN) begin fails++; $display("FAIL gate_done got=%b exp=%b", obs, DN); end
    step();
  endtask

  task automatic test_latch_invalid();
    @(negedge clk);
    parameter1 = 6'd0; parameter2 = 6'd3; start = 1'b1;
    step();
    start = 1'b0; parameter1 = 6'd5; parameter2 = 6'd1;
    tests++;
    if (obs !== 12'b100000010000) begin fails++; $display("FAIL latch_addr got=%b exp=%b", obs, 12'b100000010000); end
    step();
    tests++;
    if (obs !== 12'b000100001000) begin fails++; $display("FAIL latch_data got=%b exp=%b", obs, 12'b000100001000); end
    repeat (3) step();
    @(negedge clk);
    parameter1 = 6'd9; parameter2 = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (obs !== 12'b000000010000) begin fails++; $display("FAIL inval_addr got=%b exp=%b", obs, 12'b000000010000); end
    step();
    tests++;
    if (obs !== 12'b100000001000) begin fails++; $display("FAIL inval_data got=%b exp=%b", obs, 12'b100000001000); end
    repeat (2) step();
    tests++;
    if (obs !== DN) begin fails++; $display("FAIL inval_done got=%b exp=%b", obs, DN); end
    step();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    parameter1 = 6'd1; parameter2 = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    tests++;
    if (obs !== WR) begin fails++; $display("FAIL arst_write got=%b exp=%b", obs, WR); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL arst_immediate got=%b exp=%b", obs, Z); end
    #1 rst = 1'b0;
    step();
    tests++;
    if (obs !== Z) begin fails++; $display("FAIL arst_nodone got=%b exp=%b", obs, Z); end
    @(negedge clk);
    parameter1 = 6'd3; parameter2 = 6'd4; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (obs !== 12'b000100010000) begin fails++; $display("FAIL arst_addr got=%b exp=%b", obs, 12'b000100010000); end
    step();
    tests++;
    if (obs !== 12'b000010001000) begin fails++; $display("FAIL arst_data got=%b exp=%b", obs, 12'b000010001000); end
    repeat (2) step();
    tests++;
    if (obs !== DN) begin fails++; $display("FAIL arst_done got=%b exp=%b", obs, DN); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [11:0] pat [5] = '{12'b000001010000, 12'b000000101000, WR, DN, Z};
    int last = -1;
    @(negedge clk);
    parameter1 = 6'd5; parameter2 = 6'd6; start = 1'b1; donefetch = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      tests++;
      if (obs !== pat[i % 5]) begin fails++; $display("FAIL b2b_cyc%0d got=%b exp=%b", i, obs, pat[i % 5]); end
      tests++;
      if ($countones(obs[11:5]) > 1 || (obs[1] && !obs[2])) begin
        fails++; $display("FAIL b2b_onehot_cyc%0d got=%b exp=at most one source, RW only with EN", i, obs);
      end
      if (obs[0] === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (i - last != 5) begin fails++; $display("FAIL b2b_spacing got=%0d exp=5", i - last); end
        end
        last = i;
      end
    end
    start = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gating();
    test_latch_invalid();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
